// File: rtl/wb_sdram_master_pkg.sv
// Shared definitions for the Wishbone SDRAM initiator: cycle-type codes and
// the FSM state encoding. No ports.
package wb_master_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD
  } wbm_state_t;

endpackage

// File: rtl/wb_sdram_master_if.sv
// Wishbone B3 bus between the initiator and the SDRAM controller slave port.
//   master modport: drives cyc/stb/we/addr/dat_o/sel/cti, receives dat_i/ack
//   slave  modport: the mirror view
interface wb_sdram_master_if #(
  parameter int dw     = 32,
  parameter int APP_AW = 26
) ();

  logic              wb_cyc_o;
  logic              wb_stb_o;
  logic              wb_we_o;
  logic [APP_AW-1:0] wb_addr_o;
  logic [dw-1:0]     wb_dat_o;
  logic [dw/8-1:0]   wb_sel_o;
  logic [2:0]        wb_cti_o;
  logic [dw-1:0]     wb_dat_i;
  logic              wb_ack_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
    output wb_dat_i, wb_ack_i
  );

endinterface

// File: rtl/wb_sdram_master.sv
// Wishbone B3 initiator for the SDRAM controller. Turns read/write burst
// commands into classic (len 1) or incrementing-burst cycles, streams write
// beats in and read beats out, and only accepts work once sdr_init_done is up.
// Ports:
//   wb_clk_i, wb_resetn        clock, async active-low reset
//   sdr_init_done              memory ready; sampled in IDLE only
//   cmd_valid/ready/we/addr/len  burst command handshake (len 0 means 1)
//   wr_valid/wr_data/wr_ready  write beat stream; wr_ready marks a consumed beat
//   rd_valid/rd_data           read beat stream (one-cycle pulses, no stall)
//   done/err                   completion pulse; err also on ack timeout
//   wb                         Wishbone master view of the bus
module wb_sdram_master
  import wb_master_pkg::*;
#(
  parameter int dw      = 32,
  parameter int APP_AW  = 26,
  parameter int LEN_W   = 5,
  parameter int TIMEOUT = 1024
) (
  input  logic              wb_clk_i,
  input  logic              wb_resetn,
  input  logic              sdr_init_done,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [APP_AW-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  input  logic [dw-1:0]     wr_data,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [dw-1:0]     rd_data,
  output logic              done,
  output logic              err,
  wb_sdram_master_if.master wb
);

  localparam int                TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [APP_AW-1:0] STEP  = APP_AW'(dw / 8);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

  wbm_state_t        state_q, state_d;
  logic              cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [APP_AW-1:0] addr_q, addr_d;
  logic [dw-1:0]     dat_q, dat_d;
  logic [2:0]        cti_q, cti_d;
  logic [LEN_W-1:0]  len_q, len_d, beat_q, beat_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              rdv_q, rdv_d, done_q, done_d, err_q, err_d, rdy_q, rdy_d;
  logic [dw-1:0]     rdat_q, rdat_d;
  logic              load;
  logic              last_beat;

  assign last_beat = (beat_q == len_q - LEN_W'(1));

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    we_d    = we_q;
    addr_d  = addr_q;
    dat_d   = dat_q;
    cti_d   = cti_q;
    len_d   = len_q;
    beat_d  = beat_q;
    tmo_d   = tmo_q;
    rdat_d  = rdat_q;
    rdv_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        // rdy_q already folds in sdr_init_done and being idle
        if (cmd_valid && rdy_q) begin
          we_d   = cmd_we;
          addr_d = cmd_addr;
          len_d  = (cmd_len == '0) ? LEN_W'(1) : cmd_len;
          beat_d = '0;
          tmo_d  = '0;
          cti_d  = (cmd_len > LEN_W'(1)) ? CTI_INCR : CTI_CLASSIC;
          cyc_d  = 1'b1;
          if (!cmd_we) begin
            stb_d   = 1'b1;
            state_d = REQ;
          end else if (wr_valid) begin
            load    = 1'b1;
            stb_d   = 1'b1;
            state_d = REQ;
          end else begin
            stb_d   = 1'b0;
            state_d = HOLD;
          end
        end
      end
      REQ: begin
        if (wb.wb_ack_i) begin
          tmo_d = '0;
          if (!we_q) begin
            rdv_d  = 1'b1;
            rdat_d = wb.wb_dat_i;
          end
          if (last_beat) begin
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + LEN_W'(1);
            addr_d = addr_q + STEP;
            cti_d  = (beat_d == len_q - LEN_W'(1)) ? CTI_EOB : CTI_INCR;
            if (we_q) begin
              if (wr_valid) begin
                load = 1'b1;
              end else begin
                // source starved: park with cyc held so the burst stays open
                stb_d   = 1'b0;
                state_d = HOLD;
              end
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      HOLD: begin
        if (wr_valid) begin
          load    = 1'b1;
          stb_d   = 1'b1;
          tmo_d   = '0;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) dat_d = wr_data;
    rdy_d = (state_d == IDLE) && sdr_init_done;
  end

  always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
    if (!wb_resetn) begin
      state_q <= IDLE;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      dat_q   <= '0;
      cti_q   <= CTI_CLASSIC;
      len_q   <= '0;
      beat_q  <= '0;
      tmo_q   <= '0;
      rdv_q   <= 1'b0;
      rdat_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      dat_q   <= dat_d;
      cti_q   <= cti_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      tmo_q   <= tmo_d;
      rdv_q   <= rdv_d;
      rdat_q  <= rdat_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
    end
  end

  assign cmd_ready    = rdy_q;
  assign wr_ready     = load;
  assign rd_valid     = rdv_q;
  assign rd_data      = rdat_q;
  assign done         = done_q;
  assign err          = err_q;
  assign wb.wb_cyc_o  = cyc_q;
  assign wb.wb_stb_o  = stb_q;
  assign wb.wb_we_o   = we_q;
  assign wb.wb_addr_o = addr_q;
  assign wb.wb_dat_o  = dat_q;
  assign wb.wb_sel_o  = '1;
  assign wb.wb_cti_o  = cti_q;

endmodule

// File: tb/tb_wb_sdram_master.sv
// Bench for wb_sdram_master: directed vector table, hand-written corner
// sequences (init gate, write stall, timeout, reset mid-burst) and random
// commands checked against a beat-level memory model.
module tb_wb_sdram_master;

  localparam int DW = 32, AW = 26, LW = 5, TMO = 16, STALL = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          sdr_init_done, cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          wr_valid, wr_ready, rd_valid, done, err;
  logic [DW-1:0] wr_data, rd_data;

  wb_sdram_master_if #(.dw(DW), .APP_AW(AW)) bus ();

  wb_sdram_master #(.dw(DW), .APP_AW(AW), .LEN_W(LW), .TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_resetn(rst_n), .sdr_init_done(sdr_init_done),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_valid(wr_valid),
    .wr_data(wr_data), .wr_ready(wr_ready), .rd_valid(rd_valid),
    .rd_data(rd_data), .done(done), .err(err), .wb(bus)
  );

  // ---------------- slave model ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic [2:0]    cti;
    logic          we;
    logic [DW-1:0] dat;
  } beat_t;

  beat_t         beat_log[$];
  logic [DW-1:0] slv_mem [0:4095];
  bit            slv_wr  [0:4095];
  logic          s_ack;
  logic [DW-1:0] s_dat;
  int            ack_pct;
  int            s_wait;

  assign bus.wb_ack_i = s_ack;
  assign bus.wb_dat_i = s_dat;

  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return 32'hC0DE_0000 | {20'd0, a[13:2]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ack  <= 1'b0;
      s_wait <= 0;
    end else begin
      s_ack <= 1'b0;
      if (!s_ack && bus.wb_cyc_o && bus.wb_stb_o && ack_pct > 0 &&
          ($urandom_range(1, 100) <= ack_pct || s_wait >= 8)) begin
        s_ack  <= 1'b1;
        s_wait <= 0;
        if (bus.wb_we_o) begin
          slv_mem[bus.wb_addr_o[13:2]] <= bus.wb_dat_o;
          slv_wr[bus.wb_addr_o[13:2]]  <= 1'b1;
        end else begin
          s_dat <= slv_wr[bus.wb_addr_o[13:2]] ? slv_mem[bus.wb_addr_o[13:2]]
                                               : dflt(bus.wb_addr_o);
        end
        beat_log.push_back('{bus.wb_addr_o, bus.wb_cti_o, bus.wb_we_o, bus.wb_dat_o});
      end else if (bus.wb_cyc_o && bus.wb_stb_o && !s_ack) begin
        s_wait <= s_wait + 1;
      end
    end
  end

  // ---------------- checking ----------------
  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  logic [DW-1:0] ref_mem [int];
  logic [DW-1:0] cur_wdat [16];
  logic [DW-1:0] rd_got[$];
  int rand_wr, stall_idx, done_cnt, err_cnt, acc_t, busy_rdy;

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    int k;
    k = int'(a[13:2]);
    return ref_mem.exists(k) ? ref_mem[k] : dflt(a);
  endfunction

  // Issues one command, feeds write beats, collects read beats, then checks
  // every beat against addr+4*i / cti rules and the memory model.
  task automatic run_cmd(input logic we, input logic [AW-1:0] addr, input logic [LW-1:0] len);
    int n, idx, t, stalled;
    bit acc, fin, in_hold;
    n = (len == 0) ? 1 : int'(len);
    idx = 0; t = 0; stalled = 0; acc = 0; fin = 0; in_hold = 0;
    beat_log.delete(); rd_got.delete();
    done_cnt = 0; err_cnt = 0; acc_t = -1; busy_rdy = 0;
    while (!fin && t < 1000) begin
      @(negedge clk);
      cmd_valid = !acc; cmd_we = we; cmd_addr = addr; cmd_len = len;
      wr_data = cur_wdat[idx & 15];
      if (!we || idx >= n || (idx == stall_idx && stalled < STALL)) wr_valid = 1'b0;
      else wr_valid = (rand_wr == 0) || ($urandom_range(0, 3) != 0);
      #1;
      if (acc && !done && cmd_ready) busy_rdy++;
      if (cmd_valid && cmd_ready) begin acc = 1; acc_t = t; end
      if (wr_ready) idx++;
      if (we && idx == stall_idx && stalled < STALL) begin
        if (in_hold) begin
          chk("stall_cyc", 32'(bus.wb_cyc_o), 32'd1);
          chk("stall_stb", 32'(bus.wb_stb_o), 32'd0);
          stalled++;
        end else if (bus.wb_cyc_o && !bus.wb_stb_o) begin
          in_hold = 1; stalled++;
        end
      end
      if (rd_valid) rd_got.push_back(rd_data);
      if (err) err_cnt++;
      if (done) begin done_cnt++; fin = 1; end
      t++;
    end
    cmd_valid = 1'b0; wr_valid = 1'b0;
    chk("done_seen", 32'(fin), 32'd1);
    chk("done_cnt", 32'(done_cnt), 32'd1);
    chk("err_cnt", 32'(err_cnt), 32'd0);
    chk("busy_ready", 32'(busy_rdy), 32'd0);
    chk("beats", 32'(beat_log.size()), 32'(n));
    if (we) chk("wr_used", 32'(idx), 32'(n));
    else    chk("rd_cnt", 32'(rd_got.size()), 32'(n));
    for (int i = 0; i < n && i < beat_log.size(); i++) begin
      logic [AW-1:0] ea;
      logic [2:0]    ec;
      ea = addr + AW'(4 * i);
      ec = (n == 1) ? 3'b000 : (i == n - 1) ? 3'b111 : 3'b010;
      chk("beat_addr", 32'(beat_log[i].addr), 32'(ea));
      chk("beat_cti", 32'(beat_log[i].cti), 32'(ec));
      chk("beat_we", 32'(beat_log[i].we), 32'(we));
      if (we) begin
        chk("beat_wdat", beat_log[i].dat, cur_wdat[i]);
        ref_mem[int'(ea[13:2])] = cur_wdat[i];
      end else if (i < rd_got.size()) begin
        chk("rd_data", rd_got[i], ref_rd(ea));
      end
    end
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic [DW-1:0] d0;
    int            exp_beats;
    logic [AW-1:0] exp_last_addr;
    logic [2:0]    exp_last_cti;
    logic [DW-1:0] exp_last_rd;
  } vec_t;

  vec_t tv [10];

  initial begin
    int t, s0, s1, pulses;
    bit acc, e, d;
    tv[0] = '{1'b1, 26'h100,     5'd1,  32'hDEADBEEF, 1,  26'h100, 3'b000, 32'h0};
    tv[1] = '{1'b0, 26'h100,     5'd1,  32'h0,        1,  26'h100, 3'b000, 32'hDEADBEEF};
    tv[2] = '{1'b1, 26'h200,     5'd4,  32'd1,        4,  26'h20C, 3'b111, 32'h0};
    tv[3] = '{1'b0, 26'h200,     5'd4,  32'h0,        4,  26'h20C, 3'b111, 32'd4};
    tv[4] = '{1'b1, 26'h300,     5'd0,  32'h55,       1,  26'h300, 3'b000, 32'h0};
    tv[5] = '{1'b0, 26'h300,     5'd0,  32'h0,        1,  26'h300, 3'b000, 32'h55};
    tv[6] = '{1'b1, 26'h3FFFFF8, 5'd4,  32'hA0,       4,  26'h004, 3'b111, 32'h0};
    tv[7] = '{1'b0, 26'h3FFFFF8, 5'd4,  32'h0,        4,  26'h004, 3'b111, 32'hA3};
    tv[8] = '{1'b1, 26'h400,     5'd16, 32'h1000,     16, 26'h43C, 3'b111, 32'h0};
    tv[9] = '{1'b0, 26'h400,     5'd16, 32'h0,        16, 26'h43C, 3'b111, 32'h100F};

    // ---- reset state (inputs deliberately active) ----
    rst_n = 1'b0; sdr_init_done = 1'b1; cmd_valid = 1'b1; cmd_we = 1'b1;
    cmd_addr = '0; cmd_len = 5'd1; wr_valid = 1'b1; wr_data = '0;
    ack_pct = 100; rand_wr = 1; stall_idx = -1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_cyc", 32'(bus.wb_cyc_o), 32'd0);
    chk("rst_stb", 32'(bus.wb_stb_o), 32'd0);
    chk("rst_sel", 32'(bus.wb_sel_o), 32'hF);
    chk("rst_cti", 32'(bus.wb_cti_o), 32'd0);
    chk("rst_done_err_rdv", {29'd0, done, err, rd_valid}, 32'd0);

    // ---- init gate ----
    sdr_init_done = 1'b0; wr_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 26'h100;
    @(negedge clk); rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk); #1;
      chk("gate_ready", 32'(cmd_ready), 32'd0);
      chk("gate_cyc", 32'(bus.wb_cyc_o), 32'd0);
    end
    @(negedge clk); sdr_init_done = 1'b1;
    run_cmd(1'b0, 26'h100, 5'd1);
    chk("gate_accept_lat", 32'(acc_t), 32'd0);

    // ---- directed vector table ----
    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < 16; i++) cur_wdat[i] = tv[v].d0 + DW'(i);
      ack_pct = $urandom_range(40, 100);
      run_cmd(tv[v].we, tv[v].addr, tv[v].len);
      chk("tv_beats", 32'(beat_log.size()), 32'(tv[v].exp_beats));
      if (beat_log.size() > 0) begin
        chk("tv_last_addr", 32'(beat_log[beat_log.size()-1].addr), 32'(tv[v].exp_last_addr));
        chk("tv_last_cti", 32'(beat_log[beat_log.size()-1].cti), 32'(tv[v].exp_last_cti));
      end
      if (!tv[v].we && rd_got.size() > 0)
        chk("tv_last_rd", rd_got[rd_got.size()-1], tv[v].exp_last_rd);
    end

    // ---- write stall then read-back ----
    ack_pct = 100; rand_wr = 0; stall_idx = 2;
    cur_wdat[0] = 32'h11; cur_wdat[1] = 32'h22; cur_wdat[2] = 32'h33;
    run_cmd(1'b1, 26'h500, 5'd3);
    stall_idx = -1; rand_wr = 1;
    run_cmd(1'b0, 26'h500, 5'd3);
    if (rd_got.size() == 3) chk("stall_rd2", rd_got[2], 32'h33);

    // ---- timeout: no ack at all ----
    ack_pct = 0; t = 0; s0 = -1; s1 = -1; e = 0; d = 0; acc = 0;
    beat_log.delete();
    while (t < 200 && s1 < 0) begin
      @(negedge clk);
      cmd_valid = !acc; cmd_we = 1'b0; cmd_addr = 26'h600; cmd_len = 5'd2; wr_valid = 1'b0;
      #1;
      if (cmd_valid && cmd_ready) acc = 1;
      if (s0 < 0 && bus.wb_stb_o) s0 = t;
      if (s0 >= 0 && !bus.wb_cyc_o && s1 < 0) begin s1 = t; e = err; d = done; end
      t++;
    end
    cmd_valid = 1'b0; ack_pct = 100;
    chk("tmo_cycles", 32'(s1 - s0), 32'd16);
    chk("tmo_err", 32'(e), 32'd1);
    chk("tmo_done", 32'(d), 32'd1);
    chk("tmo_no_beats", 32'(beat_log.size()), 32'd0);
    cur_wdat[0] = 32'h7777_0001; cur_wdat[1] = 32'h7777_0002;
    run_cmd(1'b1, 26'h700, 5'd2);
    chk("tmo_next_acc", 32'(acc_t <= 1), 32'd1);

    // ---- reset in the middle of an 8-beat read ----
    beat_log.delete(); acc = 0; t = 0; pulses = 0;
    while (t < 200 && beat_log.size() < 2) begin
      @(negedge clk);
      cmd_valid = !acc; cmd_we = 1'b0; cmd_addr = 26'h200; cmd_len = 5'd8;
      #1;
      if (cmd_valid && cmd_ready) acc = 1;
      t++;
    end
    chk("rst_reach_beat2", 32'(beat_log.size() >= 2), 32'd1);
    cmd_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_cyc", 32'(bus.wb_cyc_o), 32'd0);
    chk("rst_async_stb", 32'(bus.wb_stb_o), 32'd0);
    repeat (2) begin @(negedge clk); #1; if (done || err) pulses++; end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) begin @(negedge clk); #1; if (done || err || bus.wb_cyc_o) pulses++; end
    chk("rst_no_done_err", 32'(pulses), 32'd0);
    run_cmd(1'b0, 26'h200, 5'd8);

    // ---- random commands against the model ----
    for (int k = 0; k < 40; k++) begin
      logic          rwe;
      logic [AW-1:0] ra;
      logic [LW-1:0] rl;
      rwe = 1'($urandom_range(0, 1));
      ra  = 26'h1000 + AW'($urandom_range(0, 63) * 4);
      rl  = LW'($urandom_range(0, 16));
      for (int i = 0; i < 16; i++) cur_wdat[i] = $urandom;
      ack_pct = $urandom_range(30, 100);
      run_cmd(rwe, ra, rl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
